// File: rtl/store_merge_queue.sv
// store_merge_queue: two-stage LSU store queue.
//   A speculative FIFO takes translated stores. Committed stores move to a
//   committed FIFO, which drains to the data cache port. The queue also gives
//   the load unit a page-offset hazard check against every pending store.
//
// Optional feature macro: STORE_MERGE_EN
//   defined   : a committing store that targets the same aligned word as the
//               committed tail is merged into that tail entry. It never merges
//               into the committed head.
//   undefined : every commit allocates a new committed entry.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               drop all speculative entries
//   valid_i / ready_o     store push from translation / speculative FIFO not full
//   paddr_i, data_i,
//   be_i, size_i          store payload (data pre-aligned)
//   commit_i /
//   commit_ready_o        commit the oldest speculative store / commit accepted
//   page_offset_i         load page offset to check
//   page_offset_matches_o a pending store targets the same word offset
//   no_st_pending_o       both FIFOs empty
//   req_o / gnt_i         cache write request / grant
//   req_addr_o, req_data_o,
//   req_be_o, req_size_o  committed head payload (size 3 = merged word)
module store_merge_queue #(
    parameter int unsigned SPEC_DEPTH   = 4,
    parameter int unsigned COMMIT_DEPTH = 8,
    parameter int unsigned PLEN         = 56,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned BE_W         = XLEN / 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [PLEN-1:0] paddr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [BE_W-1:0] be_i,
    input  logic [1:0]      size_i,
    input  logic            commit_i,
    output logic            commit_ready_o,
    input  logic [11:0]     page_offset_i,
    output logic            page_offset_matches_o,
    output logic            no_st_pending_o,
    output logic            req_o,
    input  logic            gnt_i,
    output logic [PLEN-1:0] req_addr_o,
    output logic [XLEN-1:0] req_data_o,
    output logic [BE_W-1:0] req_be_o,
    output logic [1:0]      req_size_o
);

    localparam int unsigned SPTR_W  = $clog2(SPEC_DEPTH);
    localparam int unsigned SCNT_W  = SPTR_W + 1;
    localparam int unsigned CPTR_W  = $clog2(COMMIT_DEPTH);
    localparam int unsigned CCNT_W  = CPTR_W + 1;
    localparam int unsigned OFF_LSB = $clog2(BE_W);

    typedef struct packed {
        logic [PLEN-1:0] paddr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
    } entry_t;

    entry_t spec_q   [SPEC_DEPTH];
    entry_t commit_q [COMMIT_DEPTH];

    logic [SPTR_W-1:0] spec_head, spec_tail;
    logic [SCNT_W-1:0] spec_count;
    logic [CPTR_W-1:0] commit_head, commit_tail;
    logic [CCNT_W-1:0] commit_count;

    entry_t spec_in;
    entry_t spec_head_e;
    logic   push, commit_fire, pop, merge_hit, alloc;

    // Word offset bits below the compare range are intentionally dropped.
    logic unused_low_bits;
    assign unused_low_bits = ^{paddr_i[OFF_LSB-1:0], page_offset_i[OFF_LSB-1:0]};

    // Incoming store, word-aligned.
    assign spec_in.paddr = {paddr_i[PLEN-1:OFF_LSB], {OFF_LSB{1'b0}}};
    assign spec_in.data  = data_i;
    assign spec_in.be    = be_i;
    assign spec_in.size  = size_i;

    assign spec_head_e = spec_q[spec_head];

    // Handshake status, all from registered state.
    assign ready_o         = spec_count != SCNT_W'(SPEC_DEPTH);
    assign commit_ready_o  = (spec_count != SCNT_W'(0)) &&
                             ((commit_count != CCNT_W'(COMMIT_DEPTH)) || merge_hit);
    assign req_o           = commit_count != CCNT_W'(0);
    assign no_st_pending_o = (spec_count == SCNT_W'(0)) && (commit_count == CCNT_W'(0));

    assign push        = valid_i && ready_o && !flush_i;
    assign commit_fire = commit_i && commit_ready_o;
    assign pop         = req_o && gnt_i;
    assign alloc       = commit_fire && !merge_hit;

    // Drain port shows the committed head; it only moves on a grant.
    assign req_addr_o = commit_q[commit_head].paddr;
    assign req_data_o = commit_q[commit_head].data;
    assign req_be_o   = commit_q[commit_head].be;
    assign req_size_o = commit_q[commit_head].size;

`ifdef STORE_MERGE_EN
    logic [CPTR_W-1:0] commit_tail_prev;
    entry_t            merged;

    assign commit_tail_prev = commit_tail - CPTR_W'(1);

    // Requiring two entries keeps the in-flight head out of the merge.
    assign merge_hit = (commit_count >= CCNT_W'(2)) &&
                       (commit_q[commit_tail_prev].paddr == spec_head_e.paddr);

    // Byte-merge the speculative head into the committed tail.
    always_comb begin : merge_calc
        merged = commit_q[commit_tail_prev];
        for (int b = 0; b < int'(BE_W); b++) begin
            if (spec_head_e.be[b]) begin
                merged.data[8*b +: 8] = spec_head_e.data[8*b +: 8];
            end
        end
        merged.be = commit_q[commit_tail_prev].be | spec_head_e.be;
        if (commit_q[commit_tail_prev].be != spec_head_e.be) begin
            merged.size = 2'd3;
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    // Payload storage; emptiness is tracked by the counters, not the contents.
    always_ff @(posedge clk_i) begin : storage
        if (push) begin
            spec_q[spec_tail] <= spec_in;
        end
`ifdef STORE_MERGE_EN
        if (commit_fire && merge_hit) begin
            commit_q[commit_tail_prev] <= merged;
        end
`endif
        if (alloc) begin
            commit_q[commit_tail] <= spec_head_e;
        end
    end

    // Pointers and counts; counts move by the net change each cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin : ptrs
        if (rst_i) begin
            spec_head    <= '0;
            spec_tail    <= '0;
            spec_count   <= '0;
            commit_head  <= '0;
            commit_tail  <= '0;
            commit_count <= '0;
        end else begin
            if (flush_i) begin
                spec_head  <= '0;
                spec_tail  <= '0;
                spec_count <= '0;
            end else begin
                if (push) begin
                    spec_tail <= spec_tail + SPTR_W'(1);
                end
                if (commit_fire) begin
                    spec_head <= spec_head + SPTR_W'(1);
                end
                spec_count <= spec_count + SCNT_W'(push) - SCNT_W'(commit_fire);
            end
            if (alloc) begin
                commit_tail <= commit_tail + CPTR_W'(1);
            end
            if (pop) begin
                commit_head <= commit_head + CPTR_W'(1);
            end
            commit_count <= commit_count + CCNT_W'(alloc) - CCNT_W'(pop);
        end
    end

    // Load hazard: any live entry or the store on the input matches the word offset.
    always_comb begin : hazard
        logic [SPTR_W-1:0] s_rel;
        logic [CPTR_W-1:0] c_rel;
        s_rel = '0;
        c_rel = '0;
        page_offset_matches_o = valid_i &&
            (paddr_i[11:OFF_LSB] == page_offset_i[11:OFF_LSB]);
        for (int i = 0; i < int'(SPEC_DEPTH); i++) begin
            s_rel = SPTR_W'(i) - spec_head;
            if ((SCNT_W'(s_rel) < spec_count) &&
                (spec_q[i].paddr[11:OFF_LSB] == page_offset_i[11:OFF_LSB])) begin
                page_offset_matches_o = 1'b1;
            end
        end
        for (int i = 0; i < int'(COMMIT_DEPTH); i++) begin
            c_rel = CPTR_W'(i) - commit_head;
            if ((CCNT_W'(c_rel) < commit_count) &&
                (commit_q[i].paddr[11:OFF_LSB] == page_offset_i[11:OFF_LSB])) begin
                page_offset_matches_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_merge_queue.sv
// Bench for store_merge_queue: a queue-level model of both FIFOs is compared
// with the DUT outputs every cycle, plus literal checks per scenario.
module tb_store_merge_queue;

    localparam int SD   = 4;
    localparam int CD   = 8;
    localparam int PLEN = 56;
    localparam int XLEN = 64;
    localparam int BE_W = 8;
    localparam int OFF  = 3;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [PLEN-1:0] paddr_i = '0;
    logic [XLEN-1:0] data_i = '0;
    logic [BE_W-1:0] be_i = '0;
    logic [1:0]      size_i = '0;
    logic            commit_i = 1'b0;
    logic            commit_ready_o;
    logic [11:0]     page_offset_i = '0;
    logic            page_offset_matches_o;
    logic            no_st_pending_o;
    logic            req_o;
    logic            gnt_i = 1'b0;
    logic [PLEN-1:0] req_addr_o;
    logic [XLEN-1:0] req_data_o;
    logic [BE_W-1:0] req_be_o;
    logic [1:0]      req_size_o;

    store_merge_queue #(
        .SPEC_DEPTH(SD), .COMMIT_DEPTH(CD), .PLEN(PLEN), .XLEN(XLEN), .BE_W(BE_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i),
        .size_i(size_i), .commit_i(commit_i), .commit_ready_o(commit_ready_o),
        .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
        .no_st_pending_o(no_st_pending_o), .req_o(req_o), .gnt_i(gnt_i),
        .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_be_o(req_be_o),
        .req_size_o(req_size_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
    } ent_t;

    ent_t sq[$];
    ent_t cq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_merge_hit();
`ifdef STORE_MERGE_EN
        if (sq.size() == 0 || cq.size() < 2) return 1'b0;
        return cq[cq.size()-1].addr == sq[0].addr;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_match();
        bit m;
        m = valid_i && (paddr_i[11:OFF] == page_offset_i[11:OFF]);
        foreach (sq[i]) if (sq[i].addr[11:OFF] == page_offset_i[11:OFF]) m = 1'b1;
        foreach (cq[i]) if (cq[i].addr[11:OFF] == page_offset_i[11:OFF]) m = 1'b1;
        return m;
    endfunction

    task automatic compare_all();
        bit cr;
        cr = (sq.size() != 0) && ((cq.size() != CD) || m_merge_hit());
        check("ready_o", 64'(ready_o), 64'(sq.size() != SD));
        check("commit_ready_o", 64'(commit_ready_o), 64'(cr));
        check("req_o", 64'(req_o), 64'(cq.size() != 0));
        check("no_st_pending_o", 64'(no_st_pending_o), 64'(sq.size() == 0 && cq.size() == 0));
        check("page_offset_matches_o", 64'(page_offset_matches_o), 64'(m_match()));
        if (cq.size() != 0) begin
            check("req_addr_o", 64'(req_addr_o), 64'(cq[0].addr));
            check("req_data_o", req_data_o, cq[0].data);
            check("req_be_o", 64'(req_be_o), 64'(cq[0].be));
            check("req_size_o", 64'(req_size_o), 64'(cq[0].size));
        end
    endtask

    task automatic model_update();
        bit   mhit, cr, do_push, do_c, do_pop;
        ent_t h, t, n;
        mhit    = m_merge_hit();
        cr      = (sq.size() != 0) && ((cq.size() != CD) || mhit);
        do_push = valid_i && (sq.size() != SD) && !flush_i;
        do_c    = commit_i && cr;
        do_pop  = (cq.size() != 0) && gnt_i;
        if (do_c) h = sq[0];
        if (do_pop) void'(cq.pop_front());
        if (do_c) begin
            if (mhit) begin
                t = cq[cq.size()-1];
                for (int b = 0; b < BE_W; b++)
                    if (h.be[b]) t.data[8*b +: 8] = h.data[8*b +: 8];
                if (t.be != h.be) t.size = 2'd3;
                t.be = t.be | h.be;
                cq[cq.size()-1] = t;
            end else begin
                cq.push_back(h);
            end
            void'(sq.pop_front());
        end
        if (flush_i) begin
            sq.delete();
        end else if (do_push) begin
            n.addr = paddr_i & ~PLEN'(BE_W - 1);
            n.data = data_i;
            n.be   = be_i;
            n.size = size_i;
            sq.push_back(n);
        end
    endtask

    // One clock: compare mid-cycle, advance the model on the edge.
    task automatic step();
        @(negedge clk_i);
        if (rst_i) begin
            sq.delete();
            cq.delete();
        end
        compare_all();
        @(posedge clk_i);
        if (!rst_i) model_update();
        #1;
    endtask

    task automatic push(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                        input logic [BE_W-1:0] be, input logic [1:0] sz);
        valid_i = 1'b1; paddr_i = a; data_i = d; be_i = be; size_i = sz;
        step();
        valid_i = 1'b0;
    endtask

    task automatic commit_all();
        commit_i = 1'b1;
        for (int k = 0; k < 16 && sq.size() != 0; k++) step();
        commit_i = 1'b0;
    endtask

    task automatic drain_all(output int n);
        n = 0;
        gnt_i = 1'b1;
        for (int k = 0; k < 40 && req_o; k++) begin
            n++;
            step();
        end
        gnt_i = 1'b0;
        check("drain_timeout", 64'(req_o), 64'd0);
    endtask

    initial begin
        int n;
        // Reset state
        step(); step();
        check("rst_req_o", 64'(req_o), 64'd0);
        check("rst_no_st_pending", 64'(no_st_pending_o), 64'd1);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        check("rst_commit_ready", 64'(commit_ready_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Page-offset hazard against a committed store
        push(56'h8000_0A48, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'd3);
        commit_i = 1'b1; step(); commit_i = 1'b0;
        page_offset_i = 12'hA4C; #1;
        check("hazard_a4c", 64'(page_offset_matches_o), 64'd1);
        page_offset_i = 12'hA50; #1;
        check("hazard_a50", 64'(page_offset_matches_o), 64'd0);
        check("hazard_req_addr", 64'(req_addr_o), 64'h8000_0A48);
        page_offset_i = 12'h000;
        drain_all(n);

        // Fill and full; full-FIFO push with a coincident commit is refused
        for (int i = 0; i < 4; i++) push(56'h500 + 56'(8*i), 64'(i + 1), 8'hFF, 2'd3);
        check("full_ready_o", 64'(ready_o), 64'd0);
        push(56'h520, 64'h55, 8'hFF, 2'd3);
        commit_i = 1'b1;
        push(56'h528, 64'h66, 8'hFF, 2'd3);
        commit_i = 1'b0;
        check("ready_after_commit", 64'(ready_o), 64'd1);
        commit_all();
        drain_all(n);
        check("fill_pops", 64'(n), 64'd4);

        // Flush with simultaneous commit
        push(56'h200, 64'hA0, 8'hFF, 2'd3);
        push(56'h208, 64'hA1, 8'hFF, 2'd3);
        push(56'h210, 64'hA2, 8'hFF, 2'd3);
        flush_i = 1'b1; commit_i = 1'b1;
        step();
        flush_i = 1'b0; commit_i = 1'b0;
        check("flush_commit_ready", 64'(commit_ready_o), 64'd0);
        check("flush_ready", 64'(ready_o), 64'd1);
        check("flush_req_addr", 64'(req_addr_o), 64'h200);
        drain_all(n);
        check("flush_pops", 64'(n), 64'd1);

        // Merge of two half-word stores to 0x2000
        push(56'h1000, 64'h0000_0000_1122_3344, 8'h0F, 2'd2);
        push(56'h2000, 64'h0000_0000_5566_7788, 8'h0F, 2'd2);
        push(56'h2000, 64'hAABB_CCDD_0000_0000, 8'hF0, 2'd2);
        commit_all();
        check("merge_head_addr", 64'(req_addr_o), 64'h1000);
        check("merge_head_be", 64'(req_be_o), 64'h0F);
        gnt_i = 1'b1; step(); gnt_i = 1'b0;
        check("merge_tail_addr", 64'(req_addr_o), 64'h2000);
`ifdef STORE_MERGE_EN
        check("merge_tail_be", 64'(req_be_o), 64'hFF);
        check("merge_tail_size", 64'(req_size_o), 64'd3);
        check("merge_tail_data", req_data_o, 64'hAABB_CCDD_5566_7788);
`else
        check("nomerge_tail_be", 64'(req_be_o), 64'h0F);
        check("nomerge_tail_size", 64'(req_size_o), 64'd2);
`endif
        drain_all(n);
`ifdef STORE_MERGE_EN
        check("merge_rest_pops", 64'(n), 64'd1);
`else
        check("nomerge_rest_pops", 64'(n), 64'd2);
`endif

        // Backpressure: head stable for 5 cycles, one grant pops exactly one
        push(56'h3000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 2'd3);
        push(56'h3008, 64'hDEAD_BEEF_0000_0002, 8'hFF, 2'd3);
        commit_all();
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_addr", 64'(req_addr_o), 64'h3000);
            check("bp_data", req_data_o, 64'hDEAD_BEEF_0000_0001);
            check("bp_be", 64'(req_be_o), 64'hFF);
        end
        gnt_i = 1'b1; step(); gnt_i = 1'b0;
        check("bp_one_pop_addr", 64'(req_addr_o), 64'h3008);
        check("bp_one_pop_req", 64'(req_o), 64'd1);
        drain_all(n);
        check("bp_rest_pops", 64'(n), 64'd1);

        // Mixed push/commit/drain traffic with repeated word addresses
        for (int i = 0; i < 16; i++) begin
            valid_i  = 1'b1;
            paddr_i  = 56'h6000 + 56'(8 * (i / 2)) + 56'(i % 2);
            data_i   = {32'(i), ~32'(i)};
            be_i     = (i % 2 == 0) ? 8'h0F : 8'hF0;
            size_i   = 2'd2;
            commit_i = (i != 0);
            gnt_i    = (i % 3 == 0);
            page_offset_i = 12'h000 + 12'(8 * (i / 2));
            step();
        end
        valid_i = 1'b0; gnt_i = 1'b0; page_offset_i = '0;
        commit_all();
        drain_all(n);

        // Reset mid-drain with 3 committed entries
        push(56'h4000, 64'h1, 8'hFF, 2'd3);
        push(56'h4008, 64'h2, 8'hFF, 2'd3);
        push(56'h4010, 64'h3, 8'hFF, 2'd3);
        commit_all();
        check("pre_rst_req", 64'(req_o), 64'd1);
        rst_i = 1'b1;
        step();
        check("mid_rst_req_o", 64'(req_o), 64'd0);
        check("mid_rst_no_st_pending", 64'(no_st_pending_o), 64'd1);
        check("mid_rst_ready_o", 64'(ready_o), 64'd1);
        check("mid_rst_commit_ready", 64'(commit_ready_o), 64'd0);
        rst_i = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/store_merge_queue.md
Name: store_merge_queue

Overview:
- Parametrised successor to the LSU store path's single-level buffering: a two-stage store queue (speculative FIFO plus committed FIFO) with configurable depths and widths.
- Adds byte-merging of committed stores that target the same aligned word.
- Sits between the store unit's address-translation stage and the data cache port.
- Also provides the page-offset hazard check used by the load unit.

Parameters:
- SPEC_DEPTH, 4: speculative entries (power of two, ≥2)
- COMMIT_DEPTH, 8: committed entries (power of two, ≥2)
- PLEN, 56: physical address width
- XLEN, 64: data width; 32 or 64
- BE_W, XLEN/8: byte-enable width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  drop all speculative entries
- valid_i  in  1  store from translation stage
- ready_o  out  1  speculative FIFO not full
- paddr_i  in  PLEN  physical address
- data_i  in  XLEN  pre-aligned write data
- be_i  in  BE_W  byte enables
- size_i  in  2  transfer size
- commit_i  in  1  commit oldest speculative store
- commit_ready_o  out  1  commit can be accepted this cycle
- page_offset_i  in  12  load address to check
- page_offset_matches_o  out  1  pending store to same word offset
- no_st_pending_o  out  1  both FIFOs empty, no request outstanding
- req_o  out  1  cache write request
- gnt_i  in  1  cache grant
- req_addr_o  out  PLEN  word-aligned address
- req_data_o  out  XLEN  write data
- req_be_o  out  BE_W  byte enables
- req_size_o  out  2  size (3 = merged, full word)

Behaviour:
- Reset: asynchronous, on rst_i high.
  - Both FIFOs are emptied and every pointer and count goes to 0.
  - req_o=0, commit_ready_o=0, page_offset_matches_o=0, no_st_pending_o=1, ready_o=1.
- Push:
  - Occurs when valid_i && ready_o && !flush_i.
  - Enqueues {paddr word-aligned to XLEN/8, data, be, size} at the speculative tail.
  - ready_o = (spec_count != SPEC_DEPTH), driven combinationally from registered state.
- Commit:
  - commit_ready_o = spec_count != 0 && (commit_count != COMMIT_DEPTH || merge_hit).
  - On commit_i && commit_ready_o, the speculative head moves to the committed FIFO with 1-cycle latency, visible to drain the next cycle.
  - commit_i while commit_ready_o=0 is ignored; the producer holds it.
- Merge (STORE_MERGE_EN only):
  - merge_hit = commit_count ≥ 2 && committed tail word address == speculative head word address.
  - On merge_hit, the commit does not allocate a new entry.
  - For each byte where the incoming be is set, the tail takes the incoming data byte; tail be |= incoming be; tail size becomes 3 unless the be values are identical.
  - The committed head is never merged into, because it may be in flight.
- Drain:
  - req_o = commit_count != 0.
  - Outputs come from the committed head and are held stable while req_o && !gnt_i.
  - On gnt_i, the head pops in the same cycle; back-to-back grants give one store per cycle.
- Simultaneous events:
  - Push, commit and drain may all occur in one cycle.
  - Counts update by net change.
  - A push into a full-minus-zero FIFO coincident with a commit is still refused, because ready_o is registered-state based.
- Flush:
  - Speculative count, head and tail go to 0 next cycle.
  - A commit accepted in the same cycle still completes.
  - A push in that cycle is dropped.
  - The committed FIFO and the drain are unaffected.
- page_offset_matches_o:
  - Combinational.
  - Set if any valid entry in either FIFO, or the current valid_i store, has paddr[11:log2(BE_W)] == page_offset_i[11:log2(BE_W)].
- no_st_pending_o: spec_count==0 && commit_count==0.
- Pointer wrap: modulo depth. Counts are log2(DEPTH)+1 bits wide so full and empty are distinguishable.

Optional Feature:
- Macro: STORE_MERGE_EN.
- Defined: merging as above, and req_size_o may be 3 for merged entries.
- Undefined: merge_hit is tied to 0, every commit allocates an entry, and req_size_o always equals the original size_i.

Test Plan:
- Reset mid-drain:
  - Stimulus: assert rst_i while req_o=1 with 3 committed entries.
  - Required: next cycle req_o=0, no_st_pending_o=1, ready_o=1, commit_ready_o=0.
- Fill and full (SPEC_DEPTH=4):
  - Stimulus: push 4 stores with commit_i=0.
  - Required: ready_o=0 after the 4th push; a 5th valid_i is not enqueued.
  - Then commit once: ready_o=1 the next cycle.
- Flush with simultaneous commit:
  - Stimulus: 3 speculative stores; assert flush_i and commit_i together.
  - Required: exactly one committed entry drains (req_addr_o = the first store's address); spec_count=0.
- Merge (macro on):
  - Stimulus: commit stores to 0x1000 (be=0x0F, data 0x11223344), then 0x2000, then 0x2000 (be=0xF0, data 0xAABBCCDD_00000000) with gnt_i=0.
  - Required: commit_count=2; the tail holds be=0xFF, size 3.
  - Macro off: commit_count=3.
- Backpressure:
  - Stimulus: hold gnt_i=0 for 5 cycles with req_o=1, then pulse gnt_i for 1 cycle.
  - Required: req_addr/data/be stable all 5 cycles; exactly one pop.
- Page-offset hazard:
  - Stimulus: committed store at 0x8000_0A48; drive page_offset_i=0xA4C (XLEN=64).
  - Required: match=1; page_offset_i=0xA50 gives 0.
